// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the SystemChip serial link.
// Contents: receiver FSM state type, oversampling and frame constants, and
// the baud divisor helper. The future transmitter reuses the divisor helper.
package kabeta_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Clocks per oversample tick. Integer division truncates, so the rate
  // error grows as CLK_FREQ approaches BAUD_RATE*OVERSAMPLE.
  function automatic int uart_div(input int clk, input int baud);
    return clk / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte delivery channel from the UART receiver to the serial port controller.
//   RxData  : byte at the FIFO head (driven by the receiver)
//   RxValid : FIFO holds at least one byte (driven by the receiver)
//   RxReady : consumer can take RxData this cycle (driven by the consumer)
// Handshake: a byte transfers on every rising edge where RxValid && RxReady.
// RxValid never depends on RxReady; RxData is stable while RxValid is high
// and not accepted. RxReady while RxValid is low has no effect.
interface uart_receiver_if
  import kabeta_uart_pkg::*;
  ;
  logic [DATA_BITS-1:0] RxData;
  logic                 RxValid;
  logic                 RxReady;

  modport master (output RxData, output RxValid, input  RxReady);
  modport slave  (input  RxData, input  RxValid, output RxReady);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO between the frame decoder and the consumer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (pointers only)
//   push, din     : write request and byte; ignored when full unless a pop
//                   happens in the same cycle
//   pop           : read request; ignored when empty
//   dout          : head entry, combinational; reads 0 while empty
//   full, empty   : occupancy flags
module uart_rx_fifo
  import kabeta_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);
  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full (wrapped) from empty.
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, the slot being popped is the one written, so both proceed.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 serial receive front end with 16x oversampling and a byte FIFO.
// Ports:
//   Clock, Reset : system clock, synchronous active-high reset
//   Rxd          : asynchronous serial line, idles high
//   rx           : byte channel to the consumer (RxData/RxValid/RxReady)
//   FrameError   : one-cycle pulse when a stop bit is sampled low
//   Overrun      : one-cycle pulse when a good byte is dropped (FIFO full)
//   Busy         : a frame is in progress (FSM not in IDLE)
//   DebugState   : current FSM state
module uart_receiver
  import kabeta_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Rxd,
  uart_receiver_if.master rx,
  output logic           FrameError,
  output logic           Overrun,
  output logic           Busy,
  output uart_rx_state_t DebugState
);
  localparam int             DIV      = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]     OS_MID   = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]     OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DW-1:0]        div_cnt;
  logic                 tick;
  logic [3:0]           os_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_sample;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  // Two-flop synchroniser; reset high so reset does not look like a start bit.
  always_ff @(posedge Clock) begin
    if (Reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], Rxd};
  end
  assign rx_s = sync_q[1];

  // Oversample tick divider, held at zero in IDLE so tick phase is
  // referenced to start-bit detection.
  assign tick = (state != IDLE) && (div_cnt == DIV_LAST);

  always_ff @(posedge Clock) begin
    if (Reset || state == IDLE) div_cnt <= '0;
    else if (tick)              div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign stop_sample = (state == STOP) && tick && (os_cnt == OS_LAST);
  assign fifo_push   = stop_sample && rx_s;
  assign fifo_pop    = rx.RxValid && rx.RxReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
    end else begin
      FrameError <= 1'b0;
      Overrun    <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os_cnt == OS_MID) begin
              // Line back high at mid start bit: treat as a glitch.
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_cnt <= '0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;  // wraps 15 -> 0 each bit
            if (os_cnt == OS_LAST) begin
              shreg   <= {rx_s, shreg[DATA_BITS-1:1]};  // LSB arrives first
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) state <= STOP;
            end
          end
        end
        STOP: begin
          if (tick) begin
            os_cnt <= os_cnt + 4'd1;
            if (os_cnt == OS_LAST) begin
              if (rx_s) begin
                Overrun <= fifo_full && !fifo_pop;
                state   <= IDLE;
              end else begin
                FrameError <= 1'b1;
                state      <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must not re-trigger START.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (Clock),
    .rst  (Reset),
    .push (fifo_push),
    .din  (shreg),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign rx.RxData  = fifo_dout;
  assign rx.RxValid = !fifo_empty;
  assign Busy       = (state != IDLE);
  assign DebugState = state;

endmodule
